conv2_stream: RTL and testbench

CONV2_STREAM -- requirements
Module: conv2_stream

---
 rtl/conv2_stream.sv | 187 ++++++++++++++++++
 tb/tb_conv2_stream.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/conv2_stream.sv
// Streaming 2-D convolution over a raster pixel stream.
// Line buffers feed a sliding window; one saturated result per full window.
module conv2_stream #(
    parameter int IMG_W     = 320,
    parameter int IMG_H     = 320,
    parameter int SIZEKer   = 3,
    parameter int WIDTH_BIT = 16,
    parameter int SHIFT     = 0
) (
    input  logic                        clock,
    input  logic                        nreset,
    input  logic                        start,
    input  logic                        relu_en,
    input  logic                        ker_we,
    input  logic [$clog2(SIZEKer)-1:0]  ker_row,
    input  logic [$clog2(SIZEKer)-1:0]  ker_col,
    input  logic signed [WIDTH_BIT-1:0] ker_data,
    input  logic                        pix_valid,
    output logic                        pix_ready,
    input  logic signed [WIDTH_BIT-1:0] pix_data,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [WIDTH_BIT-1:0] out_data,
    output logic                        out_last,
    output logic                        busy,
    output logic                        done
);
    localparam int K     = SIZEKer;
    localparam int W     = WIDTH_BIT;
    localparam int CW    = $clog2(IMG_W);
    localparam int RW    = $clog2(IMG_H);
    localparam int PW    = 2 * W;
    localparam int ACC_W = PW + $clog2(K * K);

    localparam logic signed [ACC_W-1:0] MAXV =
        {{(ACC_W-W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] MINV =
        {{(ACC_W-W+1){1'b1}}, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

    state_t state_q, state_d;
    logic [RW-1:0] row_q, row_d;
    logic [CW-1:0] col_q, col_d;
    logic relu_q, relu_d;
    logic ov_q, ov_d;
    logic last_q, last_d;
    logic done_q, done_d;
    logic signed [W-1:0] od_q, od_d;

    logic signed [W-1:0] coef_q [K][K];
    logic signed [W-1:0] coef_d [K][K];
    logic signed [W-1:0] win_q  [K][K];
    logic signed [W-1:0] win_d  [K][K];
    logic signed [W-1:0] win_n  [K][K];
    logic signed [W-1:0] lb_q   [K-1][IMG_W];
    logic signed [W-1:0] lb_d   [K-1][IMG_W];
    logic signed [W-1:0] col_v  [K];

    logic signed [PW-1:0]    prod;
    logic signed [ACC_W-1:0] acc;
    logic signed [ACC_W-1:0] shf;
    logic signed [W-1:0]     res;
    logic accept, produce, is_last, out_hs;

    assign pix_ready = (state_q == RUN) && (!ov_q || out_ready);
    assign accept    = pix_valid && pix_ready;
    assign out_hs    = ov_q && out_ready;
    assign produce   = (32'(row_q) >= K - 1) && (32'(col_q) >= K - 1);
    assign is_last   = (32'(row_q) == IMG_H - 1) && (32'(col_q) == IMG_W - 1);
    assign out_valid = ov_q;
    assign out_data  = od_q;
    assign out_last  = last_q;
    assign busy      = (state_q != IDLE);
    assign done      = done_q;

    // Column entering the window: oldest row from line buffer 0, newest is the pixel.
    always_comb begin
        for (int i = 0; i < K - 1; i++) col_v[i] = lb_q[i][col_q];
        col_v[K-1] = pix_data;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K - 1; j++) win_n[i][j] = win_q[i][j+1];
            win_n[i][K-1] = col_v[i];
        end
        win_d = win_q;
        lb_d  = lb_q;
        if (accept) begin
            win_d = win_n;
            for (int i = 0; i < K - 1; i++) lb_d[i][col_q] = col_v[i+1];
        end
    end

    always_comb begin
        acc  = '0;
        prod = '0;
        for (int i = 0; i < K; i++) begin
            for (int j = 0; j < K; j++) begin
                prod = win_n[i][j] * coef_q[i][j];
                acc  = acc + {{(ACC_W-PW){prod[PW-1]}}, prod};
            end
        end
        shf = acc >>> SHIFT;
        if (shf > MAXV)      res = MAXV[W-1:0];
        else if (shf < MINV) res = MINV[W-1:0];
        else                 res = shf[W-1:0];
        if (relu_q && res[W-1]) res = '0;
    end

    always_comb begin
        state_d = state_q;
        row_d   = row_q;
        col_d   = col_q;
        relu_d  = relu_q;
        ov_d    = ov_q;
        last_d  = last_q;
        od_d    = od_q;
        done_d  = 1'b0;
        coef_d  = coef_q;
        unique case (state_q)
            IDLE: begin
                if (ker_we && 32'(ker_row) < K && 32'(ker_col) < K)
                    coef_d[ker_row][ker_col] = ker_data;
                if (start) begin
                    state_d = RUN;
                    row_d   = '0;
                    col_d   = '0;
                    relu_d  = relu_en;
                end
            end
            RUN: begin
                if (accept) begin
                    if (32'(col_q) == IMG_W - 1) begin
                        col_d = '0;
                        row_d = row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    if (is_last) state_d = FLUSH;
                end
            end
            FLUSH: begin
                if (out_hs && last_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
        if (out_hs) begin
            ov_d   = 1'b0;
            last_d = 1'b0;
        end
        if (accept && produce) begin
            ov_d   = 1'b1;
            od_d   = res;
            last_d = is_last;
        end
    end

    always_ff @(posedge clock or negedge nreset) begin
        if (!nreset) begin
            state_q <= IDLE;
            row_q   <= '0;
            col_q   <= '0;
            relu_q  <= 1'b0;
            ov_q    <= 1'b0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
            od_q    <= '0;
            coef_q  <= '{default: '0};
            win_q   <= '{default: '0};
            lb_q    <= '{default: '0};
        end else begin
            state_q <= state_d;
            row_q   <= row_d;
            col_q   <= col_d;
            relu_q  <= relu_d;
            ov_q    <= ov_d;
            last_q  <= last_d;
            done_q  <= done_d;
            od_q    <= od_d;
            coef_q  <= coef_d;
            win_q   <= win_d;
            lb_q    <= lb_d;
        end
    end
endmodule

// File: tb/tb_conv2_stream.sv
// Directed bench for conv2_stream on a 5x5 image with a 3x3 kernel.
// Expected results are hand-computed constants.
module tb_conv2_stream;
    typedef int          kern_t [9];
    typedef logic [15:0] pix_t  [25];
    typedef int          exp_t  [9];

    logic        clock = 1'b0;
    logic        nreset = 1'b0;
    logic        start = 1'b0;
    logic        relu_en = 1'b0;
    logic        ker_we = 1'b0;
    logic [1:0]  ker_row = '0;
    logic [1:0]  ker_col = '0;
    logic signed [15:0] ker_data = '0;
    logic        pix_valid = 1'b0;
    logic        pix_ready;
    logic signed [15:0] pix_data = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic signed [15:0] out_data;
    logic        out_last;
    logic        busy;
    logic        done;

    int checks = 0;
    int errors = 0;

    logic [15:0] got[$];
    logic        lq[$];
    int          done_cnt;
    int          fv;
    int          a12;

    always #5 clock = ~clock;

    conv2_stream #(
        .IMG_W(5), .IMG_H(5), .SIZEKer(3), .WIDTH_BIT(16), .SHIFT(0)
    ) dut (
        .clock(clock), .nreset(nreset), .start(start), .relu_en(relu_en),
        .ker_we(ker_we), .ker_row(ker_row), .ker_col(ker_col),
        .ker_data(ker_data), .pix_valid(pix_valid), .pix_ready(pix_ready),
        .pix_data(pix_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_data(out_data), .out_last(out_last), .busy(busy), .done(done)
    );

    task automatic chk(input string tag, input logic [15:0] obs,
                       input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load_kernel(input kern_t k);
        for (int i = 0; i < 9; i++) begin
            @(negedge clock);
            ker_we   = 1'b1;
            ker_row  = 2'(i / 3);
            ker_col  = 2'(i % 3);
            ker_data = 16'(k[i]);
        end
        @(negedge clock);
        ker_we = 1'b0;
    endtask

    task automatic run_frame(input pix_t px, input logic relu,
                             input int st_s, input int st_n,
                             input bit noise);
        int idx;
        int post;
        bit hv;
        logic [15:0] held;
        logic acc;
        @(negedge clock);
        start   = 1'b1;
        relu_en = relu;
        @(negedge clock);
        start   = 1'b0;
        relu_en = 1'b0;
        got.delete();
        lq.delete();
        done_cnt = 0;
        fv   = -1;
        a12  = -1;
        idx  = 0;
        post = 0;
        hv   = 1'b0;
        held = '0;
        for (int cyc = 0; cyc < 200 && post < 4; cyc++) begin
            out_ready = !(cyc >= st_s && cyc < st_s + st_n);
            pix_valid = (idx < 25);
            pix_data  = (idx < 25) ? px[idx] : 16'h0;
            if (noise && busy) begin
                start    = 1'b1;
                ker_we   = 1'b1;
                ker_row  = 2'd1;
                ker_col  = 2'd1;
                ker_data = 16'sd99;
            end else begin
                start  = 1'b0;
                ker_we = 1'b0;
            end
            #1;
            if (out_valid && fv < 0) fv = cyc;
            if (out_valid && out_ready) begin
                got.push_back(out_data);
                lq.push_back(out_last);
            end
            if (out_valid && !out_ready) begin
                chk("stall_pix_ready", 16'(pix_ready), 16'h0);
                if (hv) chk("stall_hold", out_data, held);
                held = out_data;
                hv   = 1'b1;
            end else begin
                hv = 1'b0;
            end
            if (done) done_cnt++;
            if (done_cnt > 0) post++;
            acc = pix_valid && pix_ready;
            if (acc && idx == 12) a12 = cyc;
            @(negedge clock);
            if (acc) idx++;
        end
        start     = 1'b0;
        ker_we    = 1'b0;
        pix_valid = 1'b0;
        out_ready = 1'b1;
    endtask

    task automatic check_frame(input string tag, input exp_t e);
        chk({tag, "_count"}, 16'(got.size()), 16'd9);
        for (int i = 0; i < 9; i++) begin
            if (i < got.size()) begin
                chk({tag, "_data"}, got[i], 16'(e[i]));
                chk({tag, "_last"}, 16'(lq[i]), 16'(i == 8));
            end
        end
        chk({tag, "_done"}, 16'(done_cnt), 16'd1);
        chk({tag, "_latency"}, 16'(fv), 16'(a12 + 1));
    endtask

    initial begin
        pix_t  seq;
        pix_t  pmax;
        pix_t  pmin;
        kern_t kc;
        kern_t kn;
        kern_t k1;
        exp_t  e_id;
        exp_t  e_neg;
        exp_t  e_max;
        exp_t  e_min;
        exp_t  e_zero;
        int    n;

        for (int i = 0; i < 25; i++) begin
            seq[i]  = 16'(i + 1);
            pmax[i] = 16'h7FFF;
            pmin[i] = 16'h8000;
        end
        kc = '{0, 0, 0, 0, 1, 0, 0, 0, 0};
        kn = '{0, 0, 0, 0, -1, 0, 0, 0, 0};
        k1 = '{1, 1, 1, 1, 1, 1, 1, 1, 1};
        e_id   = '{7, 8, 9, 12, 13, 14, 17, 18, 19};
        e_neg  = '{-7, -8, -9, -12, -13, -14, -17, -18, -19};
        e_max  = '{32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767, 32767};
        e_min  = '{-32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768, -32768};
        e_zero = '{0, 0, 0, 0, 0, 0, 0, 0, 0};

        repeat (3) @(negedge clock);
        chk("rst_out_valid", 16'(out_valid), 16'h0);
        chk("rst_out_last", 16'(out_last), 16'h0);
        chk("rst_out_data", out_data, 16'h0);
        chk("rst_busy", 16'(busy), 16'h0);
        chk("rst_done", 16'(done), 16'h0);
        chk("rst_pix_ready", 16'(pix_ready), 16'h0);
        nreset = 1'b1;

        load_kernel(kc);
        run_frame(seq, 1'b0, 1000, 0, 1'b0);
        check_frame("identity", e_id);

        load_kernel(k1);
        run_frame(pmax, 1'b0, 1000, 0, 1'b0);
        check_frame("sat_pos", e_max);
        run_frame(pmin, 1'b0, 1000, 0, 1'b0);
        check_frame("sat_neg", e_min);

        load_kernel(kn);
        run_frame(seq, 1'b0, 1000, 0, 1'b0);
        check_frame("neg", e_neg);
        run_frame(seq, 1'b1, 1000, 0, 1'b0);
        check_frame("relu", e_zero);

        load_kernel(kc);
        run_frame(seq, 1'b0, 15, 10, 1'b0);
        check_frame("stall", e_id);

        run_frame(seq, 1'b0, 1000, 0, 1'b1);
        check_frame("run_ignore", e_id);

        @(negedge clock);
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
        chk("busy_run", 16'(busy), 16'h1);
        n = 0;
        for (int cyc = 0; cyc < 50 && n < 14; cyc++) begin
            out_ready = 1'b1;
            pix_valid = 1'b1;
            pix_data  = seq[n];
            #1;
            if (pix_ready) n++;
            @(negedge clock);
        end
        pix_valid = 1'b0;
        chk("pre_rst_accepted", 16'(n), 16'd14);
        chk("pre_rst_out_valid", 16'(out_valid), 16'h1);
        nreset = 1'b0;
        #1;
        chk("mid_rst_out_valid", 16'(out_valid), 16'h0);
        chk("mid_rst_out_data", out_data, 16'h0);
        chk("mid_rst_busy", 16'(busy), 16'h0);
        chk("mid_rst_pix_ready", 16'(pix_ready), 16'h0);
        chk("mid_rst_out_last", 16'(out_last), 16'h0);
        @(negedge clock);
        nreset = 1'b1;
        run_frame(seq, 1'b0, 1000, 0, 1'b0);
        check_frame("coef_cleared", e_zero);
        load_kernel(kc);
        run_frame(seq, 1'b0, 1000, 0, 1'b0);
        check_frame("after_rst", e_id);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
